// File: rtl/osr_tick_ctrl.sv
// Oversampling tick sequencer: divides clk into os_tick, groups ticks into symbols,
// and swaps in new div/osr settings only at symbol boundaries.
module osr_tick_ctrl #(
    parameter int CNT_W   = 10,
    parameter int OSR_W   = 5,
    parameter int DEF_DIV = 7,
    parameter int DEF_OSR = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic [OSR_W-1:0] cfg_osr,
    input  logic             start,
    input  logic             stop,
    output logic             busy,
    output logic             os_tick,
    output logic             sample_stb,
    output logic             sym_stb,
    output logic             tx_clk,
    output logic [1:0]       fsm_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

    state_t           state;
    logic [CNT_W-1:0] div_cnt;
    logic [OSR_W-1:0] phase;
    logic [CNT_W-1:0] act_div;
    logic [OSR_W-1:0] act_osr;
    logic [CNT_W-1:0] sh_div;
    logic [OSR_W-1:0] sh_osr;
    logic             pend;

    logic             xfer;
    logic             wrap;
    logic             last;
    logic             mid;
    logic             sym_edge;
    logic             to_idle;
    logic             pend_next;
    logic [OSR_W-1:0] osr_in;

    assign fsm_state = state;

    // Handshake: a config word moves when cfg_valid and cfg_ready are both high on
    // a rising clk edge; cfg_valid may be held, cfg_ready is a registered output.
    assign xfer      = cfg_valid & cfg_ready;
    assign osr_in    = (cfg_osr < OSR_W'(2)) ? OSR_W'(2) : cfg_osr;
    assign wrap      = (div_cnt >= act_div);
    assign last      = (phase >= act_osr - OSR_W'(1));
    assign mid       = (phase == (act_osr >> 1));
    assign sym_edge  = wrap & last;
    assign to_idle   = sym_edge & (stop | (state == DRAIN));
    assign pend_next = xfer | (pend & ~sym_edge);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            div_cnt    <= '0;
            phase      <= '0;
            act_div    <= CNT_W'(DEF_DIV);
            act_osr    <= OSR_W'(DEF_OSR);
            sh_div     <= '0;
            sh_osr     <= '0;
            pend       <= 1'b0;
            cfg_ready  <= 1'b1;
            busy       <= 1'b0;
            os_tick    <= 1'b0;
            sample_stb <= 1'b0;
            sym_stb    <= 1'b0;
            tx_clk     <= 1'b0;
        end else begin
            os_tick    <= 1'b0;
            sample_stb <= 1'b0;
            sym_stb    <= 1'b0;
            case (state)
                IDLE: begin
                    // A word accepted on the final boundary edge lands here.
                    if (pend) begin
                        act_div <= sh_div;
                        act_osr <= sh_osr;
                        pend    <= 1'b0;
                    end
                    if (xfer) begin
                        act_div <= cfg_div;
                        act_osr <= osr_in;
                    end
                    div_cnt   <= '0;
                    phase     <= '0;
                    tx_clk    <= 1'b0;
                    cfg_ready <= 1'b1;
                    busy      <= start;
                    if (start) state <= RUN;
                end
                default: begin
                    if (wrap) begin
                        div_cnt    <= '0;
                        os_tick    <= 1'b1;
                        sample_stb <= mid;
                        sym_stb    <= last;
                        tx_clk     <= ~tx_clk;
                        phase      <= last ? '0 : phase + OSR_W'(1);
                    end else begin
                        div_cnt <= div_cnt + CNT_W'(1);
                    end

                    if (sym_edge && pend) begin
                        act_div <= sh_div;
                        act_osr <= sh_osr;
                    end
                    if (xfer) begin
                        sh_div <= cfg_div;
                        sh_osr <= osr_in;
                    end
                    pend      <= pend_next;
                    cfg_ready <= to_idle | ~pend_next;

                    if (to_idle) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        tx_clk  <= 1'b0;
                        div_cnt <= '0;
                        phase   <= '0;
                    end else begin
                        busy <= 1'b1;
                        if (state == RUN && stop) state <= DRAIN;
                    end
                end
            endcase
        end
    end

endmodule
